// File: rtl/tdm_pkg.sv
// Shared constants and FSM encodings for the 16:1 time-division transmitter.
package tdm_pkg;

   localparam int NCH  = 16;
   localparam int SELW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tdm_mux_16x1_mux.sv
// Combinational 16:1 bit select, written with a task in the same way as the demux family.
module mux_16x1 #(
   parameter int NCH  = tdm_pkg::NCH,
   parameter int SELW = tdm_pkg::SELW
) (
   input  logic [NCH-1:0]  in,
   input  logic [SELW-1:0] sel,
   output logic            o
);

   task automatic pick(input logic [NCH-1:0] v, input logic [SELW-1:0] s, output logic b);
      b = v[s];
   endtask

   always_comb begin
      o = 1'b0;
      pick(in, sel, o);
   end

endmodule

// File: rtl/tdm_mux_16x1.sv
// Time-division 16:1 transmitter: captures a word on start, then serialises one
// channel bit per clock with its channel index, pairing with the 1x16 demux.
module tdm_mux_16x1
   import tdm_pkg::*;
#(
   parameter int NCH  = tdm_pkg::NCH,
   parameter int SELW = tdm_pkg::SELW,
   parameter bit CONT = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [NCH-1:0]  din,
   output logic            o,
   output logic [SELW-1:0] sel,
   output logic            valid,
   output logic            busy,
   output logic            done
);

   localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

   state_t          state, nxt_state;
   logic [SELW-1:0] cnt, nxt_cnt;
   logic [NCH-1:0]  shadow, nxt_shadow;
   logic            bit_nxt;

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt;
      nxt_shadow = shadow;
      case (state)
         ST_IDLE: begin
            if (start) begin
               nxt_state  = ST_SEND;
               nxt_shadow = din;
               nxt_cnt    = '0;
            end
         end
         ST_SEND: begin
            if (cnt == LAST) nxt_state = ST_DONE;
            else             nxt_cnt   = cnt + 1'b1;
         end
         ST_DONE: begin
            if (start || CONT) begin
               nxt_state  = ST_SEND;
               nxt_shadow = din;
               nxt_cnt    = '0;
            end else begin
               nxt_state = ST_IDLE;
               nxt_cnt   = '0;
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // Outputs are registered from next-state values so bit 0 appears one cycle after start.
   mux_16x1 #(.NCH(NCH), .SELW(SELW)) u_mux (
      .in  (nxt_shadow),
      .sel (nxt_cnt),
      .o   (bit_nxt)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow word is reset too, so nothing stale is ever visible after reset.
         state  <= ST_IDLE;
         cnt    <= '0;
         shadow <= '0;
         o      <= 1'b0;
         sel    <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= nxt_state;
         cnt    <= nxt_cnt;
         shadow <= nxt_shadow;
         o      <= (nxt_state == ST_SEND) && bit_nxt;
         sel    <= (nxt_state == ST_SEND) ? nxt_cnt : '0;
         valid  <= (nxt_state == ST_SEND);
         busy   <= (nxt_state != ST_IDLE);
         done   <= (nxt_state == ST_DONE);
      end
   end

endmodule

// File: tb/tb_tdm_mux_16x1.sv
// Scoreboard bench for tdm_mux_16x1: expected channel bits are queued at start and
// popped as the serial line shows them; a bench-side demux model checks loopback.
module tb_tdm_mux_16x1;

   typedef struct packed {
      logic [3:0] sel;
      logic       o;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] din;
   logic        o;
   logic [3:0]  sel;
   logic        valid;
   logic        busy;
   logic        done;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   tdm_mux_16x1 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .o     (o),
      .sel   (sel),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic push_frame(input logic [15:0] w);
      for (int k = 0; k < 16; k++) begin
         exp_t e;
         e.sel = 4'(k);
         e.o   = w[k];
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; din = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({o, sel, valid, busy, done} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset cycle %0d: got o,sel,valid,busy,done=%b expected 00000000",
                     i, {o, sel, valid, busy, done});
         end
      end
      rst = 1'b0; start = 1'b0; din = '0;
   endtask

   task automatic test_single_frame();
      exp_t e;
      @(negedge clk);
      din = 16'hA5C3; start = 1'b1; push_frame(din);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); start = 1'b0;
         vectors++;
         if (valid !== 1'b1 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL single bit %0d: got valid=%b queue=%0d expected valid=1", k, valid, exp_q.size());
         end else begin
            e = exp_q.pop_front();
            if ({sel, o} !== {e.sel, e.o}) begin
               miscompares++;
               $display("FAIL single bit %0d: got sel=%0d o=%b expected sel=%0d o=%b", k, sel, o, e.sel, e.o);
            end
         end
      end
      @(negedge clk);
      vectors++;
      if ({valid, busy, done, o, sel} !== 8'b0110_0000) begin
         miscompares++;
         $display("FAIL single done: got valid,busy,done,o,sel=%b expected 01100000", {valid, busy, done, o, sel});
      end
      @(negedge clk);
      vectors++;
      if ({valid, busy, done} !== 3'b000) begin
         miscompares++;
         $display("FAIL single idle: got valid,busy,done=%b expected 000", {valid, busy, done});
      end
   endtask

   task automatic test_loopback();
      exp_t        e;
      logic [15:0] dmx;
      logic [15:0] hit;
      int          pulses;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         din = 16'(1) << k; start = 1'b1; push_frame(din);
         hit = '0; pulses = 0;
         for (int c = 0; c < 17; c++) begin
            @(negedge clk); start = 1'b0;
            dmx = '0;
            if (valid === 1'b1) dmx[sel] = o;
            hit |= dmx;
            pulses += $countones(dmx);
            vectors++;
            if (c == 16) begin
               if (done !== 1'b1 || valid !== 1'b0) begin
                  miscompares++;
                  $display("FAIL loop k=%0d done: got done=%b valid=%b expected 1 0", k, done, valid);
               end
            end else if (valid !== 1'b1 || exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL loop k=%0d bit %0d: got valid=%b expected 1", k, c, valid);
            end else begin
               e = exp_q.pop_front();
               if ({sel, o} !== {e.sel, e.o}) begin
                  miscompares++;
                  $display("FAIL loop k=%0d bit %0d: got sel=%0d o=%b expected sel=%0d o=%b",
                           k, c, sel, o, e.sel, e.o);
               end
            end
         end
         vectors++;
         if (hit !== din || pulses !== 1) begin
            miscompares++;
            $display("FAIL loop demux k=%0d: got hit=%h pulses=%0d expected hit=%h pulses=1", k, hit, pulses, din);
         end
      end
   endtask

   task automatic test_start_ignored();
      exp_t e;
      @(negedge clk);
      din = 16'hA5C3; start = 1'b1; push_frame(din);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); start = 1'b0;
         vectors++;
         if (valid !== 1'b1 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL ignore bit %0d: got valid=%b expected 1", k, valid);
         end else begin
            e = exp_q.pop_front();
            if ({sel, o} !== {e.sel, e.o}) begin
               miscompares++;
               $display("FAIL ignore bit %0d: got sel=%0d o=%b expected sel=%0d o=%b", k, sel, o, e.sel, e.o);
            end
         end
         if (k == 5) begin
            start = 1'b1; din = 16'hFFFF;
         end
      end
      @(negedge clk);
      vectors++;
      if ({valid, done} !== 2'b01) begin
         miscompares++;
         $display("FAIL ignore done: got valid,done=%b expected 01", {valid, done});
      end
      @(negedge clk);
      vectors++;
      if ({valid, busy, done} !== 3'b000) begin
         miscompares++;
         $display("FAIL ignore idle: got valid,busy,done=%b expected 000", {valid, busy, done});
      end
      din = '0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   gaps;
      @(negedge clk);
      din = 16'h00FF; start = 1'b1;
      push_frame(16'h00FF); push_frame(16'hFF00);
      gaps = 0;
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
         if (c == 0)  din = 16'hFF00;
         if (c == 17) start = 1'b0;
         if (c < 33 && valid !== 1'b1) gaps++;
         vectors++;
         if (c == 16 || c == 33) begin
            if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL b2b done c=%0d: got valid,busy,done=%b expected 011", c, {valid, busy, done});
            end
         end else if (valid !== 1'b1 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL b2b bit c=%0d: got valid=%b expected 1", c, valid);
         end else begin
            e = exp_q.pop_front();
            if ({sel, o} !== {e.sel, e.o}) begin
               miscompares++;
               $display("FAIL b2b bit c=%0d: got sel=%0d o=%b expected sel=%0d o=%b", c, sel, o, e.sel, e.o);
            end
         end
      end
      vectors++;
      if (gaps !== 1) begin
         miscompares++;
         $display("FAIL b2b gap: got %0d idle cycles between frames expected 1", gaps);
      end
      @(negedge clk);
      vectors++;
      if ({valid, busy, done} !== 3'b000) begin
         miscompares++;
         $display("FAIL b2b idle: got valid,busy,done=%b expected 000", {valid, busy, done});
      end
   endtask

   task automatic test_abort();
      exp_t e;
      @(negedge clk);
      din = 16'h3C5A; start = 1'b1; push_frame(din);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); start = 1'b0;
         vectors++;
         if (valid !== 1'b1 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL abort pre bit %0d: got valid=%b expected 1", k, valid);
         end else begin
            e = exp_q.pop_front();
            if ({sel, o} !== {e.sel, e.o}) begin
               miscompares++;
               $display("FAIL abort pre bit %0d: got sel=%0d o=%b expected sel=%0d o=%b", k, sel, o, e.sel, e.o);
            end
         end
      end
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({o, sel, valid, busy, done} !== 8'b0) begin
         miscompares++;
         $display("FAIL abort reset: got o,sel,valid,busy,done=%b expected 00000000", {o, sel, valid, busy, done});
      end
      @(negedge clk);
      vectors++;
      if ({valid, busy, done} !== 3'b000) begin
         miscompares++;
         $display("FAIL abort no-done: got valid,busy,done=%b expected 000", {valid, busy, done});
      end
      din = 16'h9E17; start = 1'b1; push_frame(din);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); start = 1'b0;
         vectors++;
         if (valid !== 1'b1 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL abort post bit %0d: got valid=%b expected 1", k, valid);
         end else begin
            e = exp_q.pop_front();
            if ({sel, o} !== {e.sel, e.o}) begin
               miscompares++;
               $display("FAIL abort post bit %0d: got sel=%0d o=%b expected sel=%0d o=%b", k, sel, o, e.sel, e.o);
            end
         end
      end
      @(negedge clk);
      vectors++;
      if ({valid, done} !== 2'b01) begin
         miscompares++;
         $display("FAIL abort post done: got valid,done=%b expected 01", {valid, done});
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; start = 1'b0; din = '0;
      test_reset();
      test_single_frame();
      test_loopback();
      test_start_ignored();
      test_back_to_back();
      test_abort();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard drain: got %0d leftover entries expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
